// File: rtl/ph_pkg.sv
// Shared definitions for the request/pending arbiter: sizes, FSM state type
// and the fixed-priority encoder (lowest request index wins).
package ph_pkg;

    localparam int NREQ  = 4;
    localparam int IDX_W = 2;

    typedef enum logic {ST_IDLE, ST_OFFER} arb_state_t;

    // Returns {idx, any}; req[0] is highest priority and encodes as 2'b00.
    function automatic logic [IDX_W:0] prio_enc(input logic [NREQ-1:0] p);
        logic [IDX_W:0] r;
        r = '0;
        if (p[0])      r = {2'b00, 1'b1};
        else if (p[1]) r = {2'b01, 1'b1};
        else if (p[2]) r = {2'b10, 1'b1};
        else if (p[3]) r = {2'b11, 1'b1};
        return r;
    endfunction

endpackage

// File: rtl/req_pending_arbiter_prio_enc4.sv
// Combinational 4-input fixed-priority encoder wrapping the package function.
module prio_enc4
    import ph_pkg::*;
(
    input  logic [NREQ-1:0]  pend,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Lowest set bit wins; any flags a non-empty input.
    always_comb begin
        {idx, any} = prio_enc(pend);
    end

endmodule

// File: rtl/req_pending_arbiter.sv
// Synchronises four asynchronous request lines, holds each as a sticky
// pending bit and offers the highest-priority pending index on a
// valid/ready handshake. An accepted index clears its pending bit.
module req_pending_arbiter
    import ph_pkg::*;
#(
    parameter int SYNC_STAGES = 2,   // synchroniser depth, 2..4
    parameter int EDGE_MODE   = 1    // 1: rising edge sets pending, 0: level
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NREQ-1:0]  pending,
    output logic [NREQ-1:0]  overflow,
    input  logic             ovf_clr
);

    logic [NREQ-1:0]  sync_p0;      // last synchroniser stage
    logic [NREQ-1:0]  sync_p1;      // one cycle older, for edge detection
    logic [NREQ-1:0]  set;
    logic [NREQ-1:0]  clr_mask;
    logic [NREQ-1:0]  ovf_set;
    logic [NREQ-1:0]  pending_next;
    logic             accept;
    logic [IDX_W-1:0] idx_cur;
    logic             any_cur;
    logic [IDX_W-1:0] idx_next;
    logic             any_next;
    arb_state_t       state;
    arb_state_t       state_next;

    // Synchroniser: one flop chain per request line, newest sample in bit 0.
    genvar g;
    generate
        for (g = 0; g < NREQ; g++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain;

            // Shift the raw request through the chain each clock.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    chain <= '0;
                else
                    chain <= {chain[SYNC_STAGES-2:0], req[g]};
            end

            assign sync_p0[g] = chain[SYNC_STAGES-1];
        end
    endgenerate

    // Edge history of the synchronised requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sync_p1 <= '0;
        else
            sync_p1 <= sync_p0;
    end

    // Set pulses come from rising edges or from the level, by mode.
    generate
        if (EDGE_MODE != 0) begin : g_edge
            assign set     = sync_p0 & ~sync_p1;
            // Only a request landing on a bit that stays pending is lost.
            assign ovf_set = set & pending & ~clr_mask;
        end else begin : g_level
            assign set     = sync_p0;
            assign ovf_set = '0;
        end
    endgenerate

    assign accept = out_valid && out_ready;

    // Accepted bit is cleared; a same-cycle set keeps it pending.
    always_comb begin
        clr_mask = '0;
        if (accept)
            clr_mask = NREQ'(1) << out_idx;
        pending_next = (pending & ~clr_mask) | set;
    end

    prio_enc4 u_enc_cur (
        .pend (pending),
        .idx  (idx_cur),
        .any  (any_cur)
    );

    prio_enc4 u_enc_next (
        .pend (pending_next),
        .idx  (idx_next),
        .any  (any_next)
    );

    // Sticky pending bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending <= '0;
        else
            pending <= pending_next;
    end

    // Sticky overflow; a new overflow beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= '0;
        else
            overflow <= (ovf_clr ? '0 : overflow) | ovf_set;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // FSM next state: offer while anything is pending, no bubble between offers.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (any_cur) state_next = ST_OFFER;
            ST_OFFER: if (accept && !any_next) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: the index is offered exactly while in OFFER.
    always_comb begin
        out_valid = (state == ST_OFFER);
    end

    // Offered index: loaded on entry to OFFER and on each accept, frozen otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_idx <= '0;
        else if (state == ST_IDLE && any_cur)
            out_idx <= idx_cur;
        else if (state == ST_OFFER && accept && any_next)
            out_idx <= idx_next;
    end

endmodule

// File: tb/tb_req_pending_arbiter.sv
// Bench for req_pending_arbiter: directed scenarios plus a randomized run,
// all compared each cycle against a behavioural model of the request rules.
module tb_req_pending_arbiter;

    localparam int SS = 2;
    localparam int EM = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'h0;
    logic [1:0] out_idx;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] pending;
    logic [3:0] overflow;
    logic       ovf_clr = 1'b0;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Behavioural model state
    bit [3:0] hist[$];
    bit [3:0] m_pend;
    bit [3:0] m_ovf;
    bit       m_valid;
    bit [1:0] m_idx;

    req_pending_arbiter #(.SYNC_STAGES(SS), .EDGE_MODE(EM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit [1:0] lowest(input bit [3:0] p);
        for (int i = 0; i < 4; i++)
            if (p[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic m_reset();
        hist.delete();
        for (int i = 0; i <= SS; i++) hist.push_back(4'h0);
        m_pend  = '0;
        m_ovf   = '0;
        m_valid = 1'b0;
        m_idx   = '0;
    endtask

    // One clock of the request rules, using inputs present at the edge.
    task automatic m_step();
        bit [3:0] s, sd, setv, nxt;
        bit acc, clr;
        s   = hist[SS-1];
        sd  = hist[SS];
        acc = m_valid && out_ready;
        for (int i = 0; i < 4; i++) begin
            setv[i] = (EM != 0) ? (s[i] && !sd[i]) : s[i];
            clr     = acc && (m_idx == 2'(i));
            nxt[i]  = (m_pend[i] && !clr) || setv[i];
            if ((EM != 0) && setv[i] && m_pend[i] && !clr) m_ovf[i] = 1'b1;
            else if (ovf_clr)                             m_ovf[i] = 1'b0;
        end
        if (!m_valid) begin
            if (m_pend != 0) begin
                m_valid = 1'b1;
                m_idx   = lowest(m_pend);
            end
        end else if (acc) begin
            if (nxt != 0) m_idx = lowest(nxt);
            else          m_valid = 1'b0;
        end
        m_pend = nxt;
        hist.push_front(req);
        void'(hist.pop_back());
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) m_reset();
        else        m_step();
        #1;
        chk("model_pending", pending, m_pend);
        chk("model_overflow", overflow, m_ovf);
        chk("model_valid", {3'b0, out_valid}, {3'b0, m_valid});
        if (m_valid) chk("model_idx", {2'b0, out_idx}, {2'b0, m_idx});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        m_reset();

        // 1: reset holds everything idle while requests toggle
        for (int i = 0; i < 4; i++) begin
            req = (i % 2 == 0) ? 4'hF : 4'h0;
            tick();
            chk("rst_valid", {3'b0, out_valid}, 4'h0);
            chk("rst_pending", pending, 4'h0);
            chk("rst_overflow", overflow, 4'h0);
        end
        req = 4'h0;
        rst_n = 1'b1;
        out_ready = 1'b1;
        ticks(3);
        chk("post_rst_valid", {3'b0, out_valid}, 4'h0);

        // 2: single request on line 2
        req = 4'b0100;
        tick();
        req = 4'h0;
        ticks(2);
        chk("single_pending", pending, 4'b0100);
        chk("single_valid_early", {3'b0, out_valid}, 4'h0);
        tick();
        chk("single_valid", {3'b0, out_valid}, 4'h1);
        chk("single_idx", {2'b0, out_idx}, 4'b0010);
        tick();
        chk("single_done_pend", pending, 4'h0);
        chk("single_done_valid", {3'b0, out_valid}, 4'h0);

        // 3: frozen index while waiting, then back-to-back reload
        out_ready = 1'b0;
        req = 4'b1000;
        ticks(4);
        chk("prio_valid", {3'b0, out_valid}, 4'h1);
        chk("prio_idx", {2'b0, out_idx}, 4'b0011);
        req = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("prio_frozen", {2'b0, out_idx}, 4'b0011);
        end
        chk("prio_both_pend", pending, 4'b1001);
        out_ready = 1'b1;
        tick();
        chk("prio_nobubble_valid", {3'b0, out_valid}, 4'h1);
        chk("prio_nobubble_idx", {2'b0, out_idx}, 4'b0000);
        tick();
        chk("prio_end_valid", {3'b0, out_valid}, 4'h0);
        req = 4'h0;
        ticks(4);

        // 4: burst of all four requests
        req = 4'hF;
        tick();
        req = 4'h0;
        ticks(2);
        chk("burst_pend", pending, 4'hF);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("burst_valid", {3'b0, out_valid}, 4'h1);
            chk("burst_idx", {2'b0, out_idx}, 4'(i));
        end
        tick();
        chk("burst_end", {3'b0, out_valid}, 4'h0);

        // 5: collision on accept, then overflow and its clear
        out_ready = 1'b0;
        req = 4'b0010;
        tick();
        req = 4'h0;
        ticks(3);
        chk("coll_idx", {2'b0, out_idx}, 4'b0001);
        req = 4'b0010;
        tick();
        req = 4'h0;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("coll_pend", pending, 4'b0010);
        chk("coll_valid", {3'b0, out_valid}, 4'h1);
        chk("coll_idx2", {2'b0, out_idx}, 4'b0001);
        chk("coll_ovf", overflow, 4'h0);
        req = 4'b0010;
        tick();
        req = 4'h0;
        ticks(2);
        chk("ovf_set", overflow, 4'b0010);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 4'h0);
        out_ready = 1'b1;
        tick();
        chk("coll_end_valid", {3'b0, out_valid}, 4'h0);
        chk("coll_end_pend", pending, 4'h0);

        // 6: asynchronous reset in the middle of an offer
        out_ready = 1'b0;
        req = 4'b0111;
        tick();
        req = 4'h0;
        ticks(3);
        chk("mid_valid", {3'b0, out_valid}, 4'h1);
        chk("mid_pend", pending, 4'b0111);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("async_valid", {3'b0, out_valid}, 4'h0);
        chk("async_pend", pending, 4'h0);
        ticks(2);
        rst_n = 1'b1;
        ticks(2);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            req       = req ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            out_ready = ($urandom_range(0, 2) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
